// File: rtl/enc8to3_req.sv
// Active-low 8-request encoder: sticky pending bits, one index per valid/ack transaction.
// Request to valid is 2 edges; a presented code holds until acked, with at most one grant per 2 cycles.
module enc8to3_req #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [7:0] req_n,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic       gs
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state;
  logic [7:0] pend;
  logic [7:0] clr;
  logic [7:0] pend_nxt;
  logic [2:0] last;
  logic [2:0] start;
  logic [2:0] idx;
  logic [2:0] sel;
  logic       found;

  // A new low on req_n in the ack cycle re-arms the bit being retired.
  assign clr      = (valid && ack) ? (8'b0000_0001 << code) : 8'h00;
  assign pend_nxt = (pend & ~clr) | ~req_n;
  assign start    = (ROUND_ROBIN != 0) ? last + 3'd1 : 3'd0;

  always_comb begin
    sel   = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= 8'h00;
      code  <= 3'd0;
      valid <= 1'b0;
      gs    <= 1'b0;
      last  <= 3'd7;
      state <= IDLE;
    end else if (enb) begin
      // Flush drops any in-flight grant; code and last keep their values.
      pend  <= 8'h00;
      valid <= 1'b0;
      gs    <= 1'b0;
      state <= IDLE;
    end else begin
      pend <= pend_nxt;
      gs   <= |pend_nxt;
      case (state)
        IDLE: begin
          if (|pend) begin
            code  <= sel;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
            last  <= code;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
